imm_extend_pipe: RTL
====================

Name: imm_extend_pipe

Overview:
- Pipelined, parametrised immediate generator for the LEGv8 datapath.
- Takes the low 26 instruction bits plus a format select.
- Produces a DATA_W-bit extended, and optionally shifted, immediate through a 2-stage valid/ready pipeline.
- New over the single-cycle extender: MOVZ-style wide-immediate format (IW) with halfword shift, optional branch-offset scaling, illegal-format flagging with a saturating error counter, and backpressure support.

Parameters:
- DATA_W, 64, output width; legal values are 32 and 64.
- BR_SHIFT, 0, left shift applied to B and CB offsets; legal range 0..3.
- ERRCNT_W, 8, width of the saturating illegal-format counter.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- Reset_L  input  1  asynchronous, active-low reset.
- InValid  input  1  Imm26/Ctrl valid this cycle.
- InReady  output  1  block accepts input this cycle.
- Imm26  input  26  instruction bits [25:0].
- Ctrl  input  3  format: 000 I, 001 D, 010 B, 011 CB, 100 IW, 101-111 illegal.
- OutValid  output  1  BusImm/Err valid.
- OutReady  input  1  consumer accepts the output.
- BusImm  output  DATA_W  extended immediate.
- Err  output  1  current output came from an illegal format.
- ErrClr  input  1  synchronous clear of ErrCount.
- ErrCount  output  ERRCNT_W  saturating count of illegal items delivered.

Behaviour:
- Reset (Reset_L=0, asynchronous): stage valids=0, OutValid=0, BusImm=0, Err=0, ErrCount=0; InReady reads 1 once reset is released.
  - Reset mid-operation discards all in-flight items; no partial output may appear after release.
- Handshake: a transfer occurs when Valid&&Ready on the same edge.
  - OutValid, BusImm and Err hold stable while OutValid=1 and OutReady=0.
- Pipeline structure:
  - Stage 1 registers the extracted field, format and halfword.
  - Stage 2 registers the final BusImm/Err.
  - Stage k advances when it is empty or stage k+1 advances.
  - InReady = !S1valid || S1advance (combinational from OutReady; no buffer beyond two entries).
- Latency and throughput: latency 2 cycles from input transfer to OutValid with OutReady held high; throughput 1 item/cycle; order preserved.
- Format rules (sx = sign-extend to DATA_W, zx = zero-extend):
  - I: sx(Imm26[21:10]).
  - D: sx(Imm26[20:12]).
  - B: sx(Imm26[25:0]) << BR_SHIFT; bits shifted past DATA_W are dropped.
  - CB: sx(Imm26[23:5]) << BR_SHIFT.
  - IW: zx(Imm26[20:5]) << (16*Imm26[22:21]).
    - When DATA_W=32 and Imm26[22]=1: BusImm=0, Err=1.
  - Ctrl 101/110/111: BusImm=0, Err=1.
- Shift order: sign extension to DATA_W happens before the shift (truncation is the shift's only width effect).
- ErrCount:
  - Increments by 1 on each output transfer with Err=1; saturates at all-ones.
  - ErrClr has priority: on a cycle with ErrClr=1 and an Err transfer, the result is 0.
- Simultaneous in/out: with both stages full and OutReady=1, a new input is accepted the same cycle (InReady=1).
- Unknown/X on Imm26 while InValid=0 must not propagate into state.

Test Plan:
- Reset, then D with Imm26[20:12]=0x1FF, OutReady=1 -> OutValid rises exactly 2 cycles after acceptance, BusImm=0xFFFF_FFFF_FFFF_FFFF, Err=0.
- BR_SHIFT=2:
  - B with Imm26=0x2000000 -> BusImm=0xFFFF_FFFF_F800_0000.
  - CB with Imm26[23:5]=0x7FFFF -> BusImm=0xFFFF_FFFF_FFFF_FFFC.
- IW with Imm26=0x77DDE0 (hw=3, imm16=0xBEEF) -> BusImm=0xBEEF_0000_0000_0000.
  - Same stimulus with DATA_W=32 -> BusImm=0, Err=1, ErrCount=1.
- Backpressure: 4 back-to-back valid inputs (I 0x000400, D 0x001000, I 0x3FFC00, Ctrl=111), OutReady=0 for 4 cycles.
  - InReady=0 after 2 accepts; BusImm stable at item 1's value.
  - After OutReady=1: outputs in order 0x1, 0x1, 0xFFFF_FFFF_FFFF_FFFF, then Err=1.
- ERRCNT_W=2: 5 illegal items -> ErrCount reads 1, 2, 3, 3, 3. ErrClr pulsed on the 5th transfer -> 0.
- Reset_L low for 1 cycle while both stages are full -> OutValid=0 immediately (asynchronous); no stale item appears after release; next accepted item emerges 2 cycles later.

Source files
------------

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe
//   Two-stage valid/ready immediate generator for the LEGv8 datapath.
//   Stage 1 extracts the format-specific field from the instruction's low
//   26 bits and sign-extends it to 26 bits. It also captures the branch or
//   wide-immediate shift controls. Stage 2 widens the field to DATA_W,
//   applies the shift and registers BusImm/Err. A saturating counter tracks
//   illegal items as they leave the block.
//
// Parameters
//   DATA_W    output width (32 or 64)
//   BR_SHIFT  left shift applied to B and CB offsets (0..3)
//   ERRCNT_W  width of the saturating illegal-item counter
//
// Ports
//   CLK       clock, rising edge
//   Reset_L   asynchronous active-low reset
//   InValid   Imm26/Ctrl valid this cycle
//   InReady   block accepts input this cycle
//   Imm26     instruction bits [25:0]
//   Ctrl      format: 000 I, 001 D, 010 B, 011 CB, 100 IW, others illegal
//   OutValid  BusImm/Err valid
//   OutReady  consumer accepts the output
//   BusImm    extended immediate
//   Err       current output came from an illegal format
//   ErrClr    synchronous clear of ErrCount
//   ErrCount  saturating count of illegal items delivered
module imm_extend_pipe #(
  parameter int DATA_W   = 64,
  parameter int BR_SHIFT = 0,
  parameter int ERRCNT_W = 8
) (
  input  logic                CLK,
  input  logic                Reset_L,
  input  logic                InValid,
  output logic                InReady,
  input  logic [25:0]         Imm26,
  input  logic [2:0]          Ctrl,
  output logic                OutValid,
  input  logic                OutReady,
  output logic [DATA_W-1:0]   BusImm,
  output logic                Err,
  input  logic                ErrClr,
  output logic [ERRCNT_W-1:0] ErrCount
);

  localparam logic [2:0] CTRL_I  = 3'b000;
  localparam logic [2:0] CTRL_D  = 3'b001;
  localparam logic [2:0] CTRL_B  = 3'b010;
  localparam logic [2:0] CTRL_CB = 3'b011;
  localparam logic [2:0] CTRL_IW = 3'b100;

  // ---------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------
  logic s1_valid_reg;
  logic s2_valid_reg;
  logic s1_adv;
  logic s2_adv;
  logic s1_load;

  // A stage advances when it is empty or the stage after it advances.
  // The consumer stands in as the stage after stage 2.
  assign s2_adv  = !s2_valid_reg || OutReady;
  assign s1_adv  = !s1_valid_reg || s2_adv;
  assign InReady = s1_adv;
  // Stage-1 data loads only on a real transfer. Idle-cycle garbage on
  // Imm26 therefore never reaches state.
  assign s1_load = InValid && s1_adv;

  // ---------------------------------------------------------------------
  // Stage 1: field extraction
  // ---------------------------------------------------------------------
  logic [25:0] field_next;
  logic        br_next;
  logic        iw_next;
  logic        ill_next;

  // Every field is sign-extended to 26 bits here. The IW field is
  // zero-padded, so its bit 25 is 0. Stage 2 can then widen every format
  // uniformly from bit 25.
  always_comb begin
    field_next = '0;
    br_next    = 1'b0;
    iw_next    = 1'b0;
    ill_next   = 1'b0;
    case (Ctrl)
      CTRL_I:  field_next = {{14{Imm26[21]}}, Imm26[21:10]};
      CTRL_D:  field_next = {{17{Imm26[20]}}, Imm26[20:12]};
      CTRL_B: begin
        field_next = Imm26;
        br_next    = 1'b1;
      end
      CTRL_CB: begin
        field_next = {{7{Imm26[23]}}, Imm26[23:5]};
        br_next    = 1'b1;
      end
      CTRL_IW: begin
        field_next = {10'b0, Imm26[20:5]};
        iw_next    = 1'b1;
        // A 32-bit datapath has no halfwords 2 and 3.
        ill_next   = (DATA_W == 32) && Imm26[22];
      end
      default: ill_next = 1'b1;
    endcase
  end

  logic [25:0] s1_field_reg;
  logic        s1_br_reg;
  logic        s1_iw_reg;
  logic [1:0]  s1_hw_reg;
  logic        s1_ill_reg;

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      s1_valid_reg <= 1'b0;
      s1_field_reg <= '0;
      s1_br_reg    <= 1'b0;
      s1_iw_reg    <= 1'b0;
      s1_hw_reg    <= '0;
      s1_ill_reg   <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid_reg <= InValid;
      end
      if (s1_load) begin
        s1_field_reg <= field_next;
        s1_br_reg    <= br_next;
        s1_iw_reg    <= iw_next;
        s1_hw_reg    <= Imm26[22:21];
        s1_ill_reg   <= ill_next;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: widen, shift, register result
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] ext_val;
  logic [DATA_W-1:0] imm_next;

  // Sign extension happens before the shift. Bits pushed past DATA_W are
  // simply lost.
  assign ext_val = {{(DATA_W-26){s1_field_reg[25]}}, s1_field_reg};

  always_comb begin
    imm_next = ext_val;
    if (s1_br_reg) begin
      imm_next = ext_val << BR_SHIFT;
    end else if (s1_iw_reg) begin
      imm_next = ext_val << {s1_hw_reg, 4'b0000};
    end
    if (s1_ill_reg) begin
      imm_next = '0;
    end
  end

  logic [DATA_W-1:0] bus_imm_reg;
  logic              err_reg;

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      s2_valid_reg <= 1'b0;
      bus_imm_reg  <= '0;
      err_reg      <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_reg <= s1_valid_reg;
      // Data moves only with a real item, so the output holds its last
      // value while the stage drains empty.
      if (s1_valid_reg) begin
        bus_imm_reg <= imm_next;
        err_reg     <= s1_ill_reg;
      end
    end
  end

  assign OutValid = s2_valid_reg;
  assign BusImm   = bus_imm_reg;
  assign Err      = err_reg;

  // ---------------------------------------------------------------------
  // Illegal-item counter: counts delivered errors, saturates, and the
  // clear request wins over a same-cycle increment.
  // ---------------------------------------------------------------------
  logic [ERRCNT_W-1:0] err_cnt_reg;
  logic                err_xfer;

  assign err_xfer = s2_valid_reg && OutReady && err_reg;

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      err_cnt_reg <= '0;
    end else if (ErrClr) begin
      err_cnt_reg <= '0;
    end else if (err_xfer && (err_cnt_reg != {ERRCNT_W{1'b1}})) begin
      err_cnt_reg <= err_cnt_reg + ERRCNT_W'(1);
    end
  end

  assign ErrCount = err_cnt_reg;

endmodule
